// File: rtl/elevator_scheduler.sv
// Call scheduler and motion/door sequencer for a 4-floor elevator.
// Latches floor calls, tracks cabin position from floor sensors, picks direction
// with a SCAN policy and drives motor-up/down and door-open/closed outputs.
module elevator_scheduler #(
  parameter int unsigned DOOR_TICKS = 3,
  parameter int unsigned TW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] call_btn,
  input  logic [3:0] floor_sns,
  output logic       sub,
  output logic       des,
  output logic       pa,
  output logic       pf,
  output logic [3:0] pending,
  output logic [1:0] cur_floor,
  output logic       at_floor,
  output logic       erro
);

  typedef enum logic [2:0] {StIdle, StUp, StDown, StDoor, StFault} state_e;

  localparam logic [TW-1:0] DoorLast = TW'(DOOR_TICKS - 1);

  state_e        state_q, state_d;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    cur_floor_q, cur_floor_d;
  logic          dir_up_q, dir_up_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic       multi_hot;
  logic [1:0] sns_idx;
  logic [1:0] cur_idx;
  logic [3:0] pend_eff;
  logic       above, below;
  logic       door_entry;

  // Sensor decode: validity, fault detection and floor index.
  always_comb begin
    multi_hot = (floor_sns[0] & floor_sns[1]) | (floor_sns[0] & floor_sns[2]) |
                (floor_sns[0] & floor_sns[3]) | (floor_sns[1] & floor_sns[2]) |
                (floor_sns[1] & floor_sns[3]) | (floor_sns[2] & floor_sns[3]);
    at_floor  = (|floor_sns) & ~multi_hot;
    sns_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (floor_sns[i]) sns_idx = 2'(i);
    end
    // Use the live sensor so a stop is decided on the edge the floor is seen.
    cur_idx     = at_floor ? sns_idx : cur_floor_q;
    cur_floor_d = cur_idx;
  end

  // Calls ahead of / behind the cabin, including calls arriving this cycle.
  always_comb begin
    pend_eff = pending_q | call_btn;
    above    = 1'b0;
    below    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pend_eff[i]) begin
        if (2'(i) > cur_idx) above = 1'b1;
        if (2'(i) < cur_idx) below = 1'b1;
      end
    end
  end

  // Next-state, direction and door counter.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (at_floor && pend_eff[cur_idx]) begin
          state_d = StDoor;
        end else if (dir_up_q) begin
          if (above) begin
            state_d = StUp;
          end else if (below) begin
            state_d  = StDown;
            dir_up_d = 1'b0;
          end
        end else begin
          if (below) begin
            state_d = StDown;
          end else if (above) begin
            state_d  = StUp;
            dir_up_d = 1'b1;
          end
        end
      end
      StUp: begin
        if (at_floor) begin
          if (pend_eff[cur_idx])                state_d = StDoor;
          else if (cur_idx == 2'd3 || !above)   state_d = StIdle;
        end
      end
      StDown: begin
        if (at_floor) begin
          if (pend_eff[cur_idx])                state_d = StDoor;
          else if (cur_idx == 2'd0 || !below)   state_d = StIdle;
        end
      end
      StDoor: begin
        // A press at the open floor holds the door, even against a tick.
        if (call_btn[cur_idx]) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == DoorLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
    if (multi_hot) state_d = StFault;
    door_entry = (state_d == StDoor) && (state_q != StDoor);
    if (door_entry) cnt_d = '0;
  end

  // Call latching: new presses set, arrival at the floor clears (clear wins).
  always_comb begin
    pending_d = pending_q | call_btn;
    if (state_q == StDoor) pending_d[cur_idx] = pending_q[cur_idx];
    if (door_entry)        pending_d[cur_idx] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    sub       = (state_q == StUp);
    des       = (state_q == StDown);
    pa        = (state_q == StDoor);
    pf        = ~pa;
    erro      = (state_q == StFault);
    pending   = pending_q;
    cur_floor = cur_floor_q;
  end

endmodule
